axi_wdata_router: RTL
=====================

Name: axi_wdata_router

Overview:
- Write-data (W) channel stage that sits downstream of the AW address decoder in each target-side slice of the AXI node.
- Queues the one-hot destination vectors that the AW decoder pushes, one per accepted AW.
- Routes W beats, in AW order, to the selected initiator port, popping one entry per burst on wlast.
- When the AW decoder reports a decode error, sinks and discards the W burst of the erroneous AW, then signals completion.

Parameters:
- N_INIT_PORT, 8, number of initiator (slave-side) ports; width of one-hot destination vector.
- FIFO_DEPTH, 8, destination FIFO entries (power of two, >=2).
- LOG_FIFO_DEPTH, 3, log2(FIFO_DEPTH).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- push_DEST_i  input  1  push one destination entry (AW accepted, no error).
- DEST_i  input  N_INIT_PORT  one-hot destination for the pushed AW.
- grant_FIFO_DEST_o  output  1  FIFO can accept a push (not full).
- wvalid_i  input  1  upstream W beat valid.
- wlast_i  input  1  upstream W beat is last of burst.
- wready_o  output  1  upstream W beat accepted.
- wvalid_o  output  N_INIT_PORT  per-port W valid.
- wready_i  input  N_INIT_PORT  per-port W ready.
- handle_error_i  input  1  AW decoder requests the drain of one erroneous W burst.
- wdata_error_completed_o  output  1  single-cycle pulse: erroneous burst fully drained.

Behaviour:
- Reset: FIFO empty (rd/wr pointers and count = 0), FSM = ROUTE, wready_o = 0, wvalid_o = 0, wdata_error_completed_o = 0, grant_FIFO_DEST_o = 1.
- FIFO: count is LOG_FIFO_DEPTH+1 bits and pointers wrap modulo FIFO_DEPTH. grant_FIFO_DEST_o = ~full, with no bypass when full, even if a pop occurs in the same cycle. A push while full is ignored; the bench asserts this never happens. Simultaneous push and pop when not full leaves count unchanged.
- No push-to-route bypass: a destination pushed in cycle N can route W beats from cycle N+1.
- ROUTE state, FIFO not empty, head = H:
  - wvalid_o = H & {N{wvalid_i}}.
  - wready_o = |(H & wready_i).
  - Beat handshake = wvalid_i & wready_o.
  - Pop on handshake & wlast_i.
  - Combinational path wready_i -> wready_o; no pipeline register, so zero added latency.
- ROUTE state, FIFO empty: wvalid_o = 0 and wready_o = 0, with the W beat stalled.
- Error entry: ROUTE -> ERR_DRAIN when handle_error_i = 1 and FIFO empty. If the FIFO is not empty, queued bursts route first, because they belong to older AWs.
- ERR_DRAIN state:
  - wready_o = 1 and wvalid_o = 0; beats are discarded.
  - Handshake with wlast_i -> ERR_DONE.
  - Pushes are still accepted into the FIFO.
- ERR_DONE state:
  - wdata_error_completed_o = 1 for exactly one cycle; wready_o = 0.
  - Next state WAIT_CLR.
- WAIT_CLR state: wready_o = 0. Go to ROUTE once handle_error_i = 0. This prevents a second drain on the stale request still held by the AW decoder.
- Single-beat error burst (wlast_i on the first beat) takes ERR_DRAIN -> ERR_DONE in one beat.
- Reset mid-burst: everything returns to reset values immediately (asynchronous). Queued destinations are lost; the system resets together.
- The state register is 2 bits; the enum is {ROUTE, ERR_DRAIN, ERR_DONE, WAIT_CLR}.

Decomposition:
- Shared package axi_node_pkg holds the state enum type for this FSM.
- The one-hot check helper function for assertions is defined in the verification package, not in RTL.
- One natural sub-module, axi_dest_fifo:
  - Parameterised width N_INIT_PORT, depth FIFO_DEPTH.
  - Ports push/data_in/full and pop/data_out/empty.
- The top level contains the FSM and routing mux/demux.

Test Plan:
- Push DEST=8'b0000_0100, then a 4-beat burst with all wready_i=1 -> wvalid_o[2] high for 4 cycles, pop on beat 4, FIFO empty, grant stays 1.
- Push 8 entries with no W traffic -> grant_FIFO_DEST_o = 0 after the 8th push. Then pop one (single-beat burst) -> grant returns to 1 the next cycle, and a push in the pop cycle is rejected.
- Push DEST=0x01 then DEST=0x80, two 2-beat bursts, wready_i[0] toggled 1,0,1 -> beats reach port 0 then port 7 in order, with wready_o following wready_i[0].
- handle_error_i=1 with FIFO empty, 3-beat W burst -> wready_o=1 for 3 beats, wvalid_o=0, completed pulses 1 cycle after the wlast beat. While handle_error_i stays high for 2 more cycles, no second pulse.
- handle_error_i=1 while 1 entry is queued for port 3 -> the port-3 burst routes first, then the error burst drains, then the pulse.
- Assert rst_n=0 mid-burst (beat 2 of 4) -> wvalid_o=0, wready_o=0, grant=1 asynchronously, and the FIFO is empty after reset release.

Source files
------------

// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: W-channel router FSM state type and default sizing.
package axi_node_pkg;

    localparam int DEFAULT_N_INIT_PORT    = 8;
    localparam int DEFAULT_FIFO_DEPTH     = 8;
    localparam int DEFAULT_LOG_FIFO_DEPTH = 3;

    typedef enum logic [1:0] {
        ROUTE     = 2'd0,
        ERR_DRAIN = 2'd1,
        ERR_DONE  = 2'd2,
        WAIT_CLR  = 2'd3
    } wdata_state_e;

endpackage

// File: rtl/axi_wdata_router_if.sv
// W-channel router bundle: destination push from the AW decoder, upstream W beat,
// per-port W valid/ready and the decode-error drain handshake.
interface axi_wdata_router_if
    import axi_node_pkg::*;
#(
    parameter int N_INIT_PORT = DEFAULT_N_INIT_PORT
);

    logic                   push_DEST_i;
    logic [N_INIT_PORT-1:0] DEST_i;
    logic                   grant_FIFO_DEST_o;

    logic                   wvalid_i;
    logic                   wlast_i;
    logic                   wready_o;

    logic [N_INIT_PORT-1:0] wvalid_o;
    logic [N_INIT_PORT-1:0] wready_i;

    logic                   handle_error_i;
    logic                   wdata_error_completed_o;

    // Environment side: AW decoder, upstream W source and the initiator ports.
    modport master (
        output push_DEST_i, DEST_i, wvalid_i, wlast_i, wready_i, handle_error_i,
        input  grant_FIFO_DEST_o, wready_o, wvalid_o, wdata_error_completed_o
    );

    // Router side.
    modport slave (
        input  push_DEST_i, DEST_i, wvalid_i, wlast_i, wready_i, handle_error_i,
        output grant_FIFO_DEST_o, wready_o, wvalid_o, wdata_error_completed_o
    );

endinterface

// File: rtl/axi_dest_fifo.sv
// Destination FIFO: holds one one-hot port vector per accepted AW, read in AW order.
module axi_dest_fifo
    import axi_node_pkg::*;
#(
    parameter int N_INIT_PORT    = DEFAULT_N_INIT_PORT,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int LOG_FIFO_DEPTH = DEFAULT_LOG_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [N_INIT_PORT-1:0] data_in,
    output logic                   full,
    input  logic                   pop,
    output logic [N_INIT_PORT-1:0] data_out,
    output logic                   empty
);

    localparam logic [LOG_FIFO_DEPTH:0] FULL_COUNT = (LOG_FIFO_DEPTH+1)'(FIFO_DEPTH);

    logic [N_INIT_PORT-1:0]    mem [FIFO_DEPTH];
    logic [LOG_FIFO_DEPTH-1:0] rd_ptr;
    logic [LOG_FIFO_DEPTH-1:0] wr_ptr;
    logic [LOG_FIFO_DEPTH:0]   count;
    logic                      push_ok;
    logic                      pop_ok;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign data_out = mem[rd_ptr];

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; empty is derived from count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/axi_wdata_router.sv
// W-channel router: steers W bursts to the port chosen by the AW decoder, in AW order,
// and sinks the W burst of an AW that failed decode.
module axi_wdata_router
    import axi_node_pkg::*;
#(
    parameter int N_INIT_PORT    = DEFAULT_N_INIT_PORT,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int LOG_FIFO_DEPTH = DEFAULT_LOG_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    axi_wdata_router_if.slave  bus
);

    wdata_state_e           state;
    wdata_state_e           state_next;

    logic [N_INIT_PORT-1:0] head;
    logic                   full;
    logic                   empty;
    logic                   pop;

    logic                   wready;
    logic [N_INIT_PORT-1:0] wvalid;
    logic                   completed;

    axi_dest_fifo #(
        .N_INIT_PORT    (N_INIT_PORT),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .LOG_FIFO_DEPTH (LOG_FIFO_DEPTH)
    ) u_dest_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (bus.push_DEST_i),
        .data_in  (bus.DEST_i),
        .full     (full),
        .pop      (pop),
        .data_out (head),
        .empty    (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ROUTE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        wready     = 1'b0;
        wvalid     = '0;
        pop        = 1'b0;
        completed  = 1'b0;

        unique case (state)
            ROUTE: begin
                if (!empty) begin
                    // Ready passes straight through from the selected port: no added latency.
                    wvalid = head & {N_INIT_PORT{bus.wvalid_i}};
                    wready = |(head & bus.wready_i);
                    pop    = bus.wvalid_i & wready & bus.wlast_i;
                end else if (bus.handle_error_i) begin
                    // Queued bursts belong to older AWs, so the drain waits for an empty FIFO.
                    state_next = ERR_DRAIN;
                end
            end
            ERR_DRAIN: begin
                wready = 1'b1;
                if (bus.wvalid_i && bus.wlast_i) state_next = ERR_DONE;
            end
            ERR_DONE: begin
                completed  = 1'b1;
                state_next = WAIT_CLR;
            end
            WAIT_CLR: begin
                // The decoder still holds its request this cycle; wait it out to avoid a second drain.
                if (!bus.handle_error_i) state_next = ROUTE;
            end
            default: state_next = ROUTE;
        endcase
    end

    assign bus.grant_FIFO_DEST_o       = ~full;
    assign bus.wready_o                = wready;
    assign bus.wvalid_o                = wvalid;
    assign bus.wdata_error_completed_o = completed;

endmodule
